// File: rtl/ram_line_port.sv
// Line transfer engine between the cache controller and a fixed-latency synchronous RAM.
// Writes back a buffered victim line and fetches a missing line one word at a time.
module ram_line_port #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int RAM_LATENCY    = 2
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            RAMreadEnable,
  input  logic                                            RAMwriteEnable,
  input  logic [ADDR_WIDTH-1:0]                           readLineAddr,
  input  logic [ADDR_WIDTH-1:0]                           writeLineAddr,
  input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0]            writeLineData,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0]            readLineData,
  output logic                                            dataReady,
  output logic                                            busy,
  output logic                                            writeOverrun,
  output logic [ADDR_WIDTH+$clog2(WORDS_PER_LINE)-1:0]    ramAddr,
  output logic [DATA_WIDTH-1:0]                           ramDataOut,
  output logic                                            ramWe,
  output logic                                            ramRe,
  input  logic [DATA_WIDTH-1:0]                           ramDataIn
);

  localparam int IDX_W  = $clog2(WORDS_PER_LINE);
  localparam int SLOT_W = $clog2(RAM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WB, FETCH, DONE} state_t;

  state_t                  state;
  state_t                  nextState;
  logic [SLOT_W-1:0]       slot;
  logic [IDX_W-1:0]        idx;
  logic [ADDR_WIDTH-1:0]   wbLine;
  logic [ADDR_WIDTH-1:0]   rdLine;
  logic [DATA_WIDTH-1:0]   wbBuf [WORDS_PER_LINE];
  logic                    lastSlot;
  logic                    lineEnd;
  logic                    acceptWrite;
  logic                    startFetch;

  assign lastSlot    = (slot == SLOT_W'(RAM_LATENCY));
  assign lineEnd     = lastSlot && (idx == IDX_W'(WORDS_PER_LINE - 1));
  assign acceptWrite = (state == IDLE) && RAMwriteEnable;
  // A fetch starts from IDLE (write has priority) or straight out of a finished write-back.
  assign startFetch  = RAMreadEnable &&
                       (((state == IDLE) && !RAMwriteEnable) || ((state == WB) && lineEnd));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (RAMwriteEnable) begin
          nextState = WB;
        end else if (RAMreadEnable) begin
          nextState = FETCH;
        end
      end
      WB: begin
        if (lineEnd) begin
          nextState = RAMreadEnable ? FETCH : IDLE;
        end
      end
      FETCH: begin
        if (!RAMreadEnable) begin
          nextState = IDLE;
        end else if (lineEnd) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (!RAMreadEnable) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    dataReady  = (state == DONE);
    ramWe      = (state == WB) && (slot == '0);
    ramRe      = (state == FETCH) && (slot == '0);
    ramAddr    = '0;
    ramDataOut = '0;
    if (state == WB) begin
      ramAddr    = {wbLine, idx};
      ramDataOut = wbBuf[idx];
    end else if (state == FETCH) begin
      ramAddr    = {rdLine, idx};
    end
  end

  // Slot and word counters restart whenever a transfer begins, ends or is aborted.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
      idx  <= '0;
    end else if (((state == WB) || (state == FETCH)) && (nextState == state)) begin
      if (lastSlot) begin
        slot <= '0;
        idx  <= idx + 1'b1;
      end else begin
        slot <= slot + 1'b1;
      end
    end else begin
      slot <= '0;
      idx  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wbLine       <= '0;
      rdLine       <= '0;
      writeOverrun <= 1'b0;
      readLineData <= '0;
    end else begin
      if (acceptWrite) begin
        wbLine <= writeLineAddr;
      end
      if (startFetch) begin
        rdLine <= readLineAddr;
      end
      if (RAMwriteEnable && (state != IDLE)) begin
        writeOverrun <= 1'b1;
      end
      if ((state == FETCH) && lastSlot) begin
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
          if (idx == IDX_W'(i)) begin
            readLineData[i*DATA_WIDTH +: DATA_WIDTH] <= ramDataIn;
          end
        end
      end
    end
  end

  // Victim line data needs no reset; it is only read while WB is active.
  always_ff @(posedge clk) begin
    if (!reset && acceptWrite) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        wbBuf[i] <= writeLineData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule
